// File: rtl/lsu_mem_master.sv
// Purpose: load/store initiator between the execute stage and the data-memory port.
// Latency: response MEM_WAIT+1 cycles after the accept cycle (1 cycle for faulting requests).
// Backpressure: one access in flight; req_ready stays low until the response handshake completes.
module lsu_mem_master #(
  parameter int XLEN     = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_ren,
  output logic            mem_wen,
  output logic [7:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            mem_ren_q;
  logic            mem_wen_q;
  logic [7:0]      mem_wmask_q;
  logic [XLEN-1:0] mem_wdata_q;

  logic [1:0]      req_off;
  logic            req_illegal;
  logic            req_misalign;
  logic            req_err;
  logic [3:0]      lane_mask;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] resp_rdata_d;

  assign req_off = req_addr[1:0];

  // Decode the incoming request: fault detection and store lane placement.
  always_comb begin
    // funct3[1:0]==11 is never legal; bit 2 is only legal on lb/lh (lbu/lhu).
    req_illegal  = (req_funct3[1:0] == 2'b11) ||
                   (req_funct3[2] && (req_wen || req_funct3[1]));
    req_misalign = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
    req_err      = req_illegal || req_misalign;
    lane_mask    = 4'hF;
    lane_wdata   = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        lane_mask  = 4'b0001 << req_off;
        lane_wdata = {(XLEN/8){req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask  = 4'b0011 << req_off;
        lane_wdata = {(XLEN/16){req_wdata[15:0]}};
      end
      default: begin
        lane_mask  = 4'hF;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // Extract and extend the addressed bytes of the returning memory word.
  always_comb begin
    rd_shifted   = mem_rdata >> {off_q, 3'b000};
    resp_rdata_d = rd_shifted;
    case (funct3_q)
      3'b000:  resp_rdata_d = {{(XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
      3'b100:  resp_rdata_d = {{(XLEN-8){1'b0}}, rd_shifted[7:0]};
      3'b001:  resp_rdata_d = {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      3'b101:  resp_rdata_d = {{(XLEN-16){1'b0}}, rd_shifted[15:0]};
      default: resp_rdata_d = rd_shifted;
    endcase
  end

  // Access sequencer with all handshake and memory outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_wmask_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q  <= 1'b0;
            store_q      <= req_wen;
            funct3_q     <= req_funct3;
            off_q        <= req_off;
            resp_rdata_q <= '0;
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q     <= ACCESS;
              resp_err_q  <= 1'b0;
              cnt_q       <= 4'(MEM_WAIT - 1);
              mem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
              mem_ren_q   <= !req_wen;
              // The memory commits every cycle wen is high, so the write
              // strobe only covers the last cycle of the access window.
              mem_wen_q   <= req_wen && (MEM_WAIT == 1);
              mem_wmask_q <= req_wen ? {4'b0000, lane_mask} : 8'h00;
              mem_wdata_q <= req_wen ? lane_wdata : '0;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            if (!store_q) resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= '0;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_wmask_q  <= '0;
            mem_wdata_q  <= '0;
          end else begin
            cnt_q     <= cnt_q - 4'd1;
            mem_wen_q <= store_q && (cnt_q == 4'd1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_ren    = mem_ren_q;
  assign mem_wen    = mem_wen_q;
  assign mem_wmask  = mem_wmask_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: three instances with MEM_WAIT = 1, 3, 4.
// Expected values are hand-computed constants per request.
// Memory-side activity is tallied on the falling edge by a passive monitor.
module tb_lsu_mem_master;

  logic        clock;
  logic        reset      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_wen    [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic [31:0] mem_addr   [3];
  logic        mem_ren    [3];
  logic        mem_wen    [3];
  logic [7:0]  mem_wmask  [3];
  logic [31:0] mem_wdata  [3];
  logic [31:0] mem_rdata  [3];

  int checks   = 0;
  int failures = 0;

  int          wen_cnt [3];
  int          ren_cnt [3];
  int          both_cnt;
  logic [31:0] w_addr  [3];
  logic [31:0] w_data  [3];
  logic [7:0]  w_mask  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_mem_master #(.XLEN(32), .MEM_WAIT(g == 0 ? 1 : g + 2)) u_dut (
      .clock      (clock),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_wen    (req_wen[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .mem_addr   (mem_addr[g]),
      .mem_ren    (mem_ren[g]),
      .mem_wen    (mem_wen[g]),
      .mem_wmask  (mem_wmask[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory-side monitor.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_wen[k]) begin
        wen_cnt[k] = wen_cnt[k] + 1;
        w_addr[k]  = mem_addr[k];
        w_data[k]  = mem_wdata[k];
        w_mask[k]  = mem_wmask[k];
      end
      if (mem_ren[k]) ren_cnt[k] = ren_cnt[k] + 1;
      if (mem_ren[k] && mem_wen[k]) both_cnt = both_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int mw_of(input int i);
    return (i == 0) ? 1 : i + 2;
  endfunction

  // Present a request and return once it has been accepted (posedge).
  task automatic issue(input int i, input bit wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mrd, input string tag);
    int n = 0;
    @(negedge clock);
    while (!req_ready[i] && n < 30) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, "_ready"}, 32'(req_ready[i]), 32'd1);
    req_valid[i]  = 1'b1;
    req_wen[i]    = wen;
    req_funct3[i] = f3;
    req_addr[i]   = addr;
    req_wdata[i]  = wdata;
    mem_rdata[i]  = mrd;
    @(posedge clock);
  endtask

  // Full transaction: issue, wait for response, check timing and contents.
  task automatic run(input int i, input bit wen, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] mrd, input bit exp_err,
                     input logic [31:0] exp_rdata, input string tag);
    int w0, r0, lat, exp_lat;
    w0 = wen_cnt[i];
    r0 = ren_cnt[i];
    issue(i, wen, f3, addr, wdata, mrd, tag);
    lat = 0;
    do begin
      @(negedge clock);
      req_valid[i] = 1'b0;
      lat++;
    end while (!resp_valid[i] && lat < 30);
    exp_lat = exp_err ? 1 : mw_of(i) + 1;
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_err"}, 32'(resp_err[i]), 32'(exp_err));
    check_val({tag, "_rdata"}, resp_rdata[i], exp_rdata);
    check_val({tag, "_wens"}, 32'(wen_cnt[i] - w0), (wen && !exp_err) ? 32'd1 : 32'd0);
    check_val({tag, "_rens"}, 32'(ren_cnt[i] - r0), (!wen && !exp_err) ? 32'(mw_of(i)) : 32'd0);
  endtask

  initial begin
    both_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b0; req_valid[k] = 1'b0; req_wen[k] = 1'b0;
      req_funct3[k] = 3'b000; req_addr[k] = '0; req_wdata[k] = '0;
      resp_ready[k] = 1'b1; mem_rdata[k] = '0;
      wen_cnt[k] = 0; ren_cnt[k] = 0;
      w_addr[k] = '0; w_data[k] = '0; w_mask[k] = '0;
    end
    repeat (3) @(negedge clock);
    check_val("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check_val("rst_resp", {29'd0, resp_valid[0], resp_err[0], mem_ren[0]}, 32'd0);
    check_val("rst_rdata", resp_rdata[0], 32'd0);
    check_val("rst_mem_addr", mem_addr[0] | mem_wdata[0], 32'd0);
    check_val("rst_mem_ctl", {23'd0, mem_wen[0], mem_wmask[0]}, 32'd0);
    for (int k = 0; k < 3; k++) reset[k] = 1'b1;

    // Instance 0: MEM_WAIT = 1.
    run(0, 1'b1, 3'b010, 32'h8000_0104, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, "sw");
    check_val("sw_addr", w_addr[0], 32'h8000_0104);
    check_val("sw_mask", 32'(w_mask[0]), 32'h0000_000F);
    check_val("sw_data", w_data[0], 32'hDEAD_BEEF);

    run(0, 1'b1, 3'b000, 32'h8000_0103, 32'h0000_00F0, 32'h0, 1'b0, 32'h0, "sb");
    check_val("sb_addr", w_addr[0], 32'h8000_0100);
    check_val("sb_mask", 32'(w_mask[0]), 32'h0000_0008);
    check_val("sb_data", w_data[0], 32'hF0F0_F0F0);

    run(0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 1'b0, 32'h0, "sh");
    check_val("sh_addr", w_addr[0], 32'h8000_0000);
    check_val("sh_mask", 32'(w_mask[0]), 32'h0000_000C);
    check_val("sh_data", w_data[0], 32'hABCD_ABCD);

    run(0, 1'b0, 3'b000, 32'h8000_0103, 32'h0, 32'hF000_0000, 1'b0, 32'hFFFF_FFF0, "lb");
    run(0, 1'b0, 3'b100, 32'h8000_0103, 32'h0, 32'hF000_0000, 1'b0, 32'h0000_00F0, "lbu");
    run(0, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_ABCD, 1'b0, 32'hFFFF_8001, "lh");
    run(0, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_ABCD, 1'b0, 32'h0000_8001, "lhu");
    run(0, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h1234_5678, 1'b0, 32'h1234_5678, "lw");
    run(0, 1'b0, 3'b001, 32'h8000_0000, 32'h0, 32'h8001_7ABC, 1'b0, 32'h0000_7ABC, "lh_lo");

    // Faulting requests.
    run(0, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1111_1111, 1'b1, 32'h0, "lw_mis");
    run(0, 1'b1, 3'b001, 32'h8000_0001, 32'h5555_5555, 32'h0, 1'b1, 32'h0, "sh_mis");
    run(0, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h2222_2222, 1'b1, 32'h0, "ld_f011");
    run(0, 1'b1, 3'b100, 32'h8000_0000, 32'h6666_6666, 32'h0, 1'b1, 32'h0, "st_f100");
    run(0, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_8000, 1'b0, 32'hFFFF_FF80, "lb_ok");

    // Instance 1: MEM_WAIT = 3 with response backpressure.
    resp_ready[1] = 1'b0;
    run(1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, "bp_lw");
    req_valid[1]  = 1'b1;
    req_wen[1]    = 1'b0;
    req_funct3[1] = 3'b100;
    req_addr[1]   = 32'h8000_0011;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_val("bp_hold_valid", 32'(resp_valid[1]), 32'd1);
      check_val("bp_hold_rdata", resp_rdata[1], 32'hCAFE_F00D);
      check_val("bp_hold_ready", 32'(req_ready[1]), 32'd0);
      check_val("bp_hold_ren", 32'(mem_ren[1]), 32'd0);
    end
    resp_ready[1] = 1'b1;
    @(negedge clock);
    check_val("bp_done_valid", 32'(resp_valid[1]), 32'd0);
    check_val("bp_done_ready", 32'(req_ready[1]), 32'd1);
    check_val("bp_done_ren", 32'(mem_ren[1]), 32'd0);
    @(negedge clock);
    req_valid[1] = 1'b0;
    check_val("bp_next_ren", 32'(mem_ren[1]), 32'd1);
    check_val("bp_next_addr", mem_addr[1], 32'h8000_0010);
    begin
      int n = 0;
      while (!resp_valid[1] && n < 30) begin
        @(negedge clock);
        n++;
      end
      check_val("bp_next_lat", 32'(n), 32'd3);
      check_val("bp_next_rdata", resp_rdata[1], 32'h0000_00F0);
    end

    // Instance 2: MEM_WAIT = 4, reset in the middle of a store.
    begin
      int w0 = wen_cnt[2];
      issue(2, 1'b1, 3'b010, 32'h8000_0020, 32'h1122_3344, 32'h0, "rst_sw");
      @(negedge clock);
      req_valid[2] = 1'b0;
      @(negedge clock);
      reset[2] = 1'b0;
      repeat (2) @(negedge clock);
      reset[2] = 1'b1;
      repeat (6) @(negedge clock);
      check_val("midrst_wens", 32'(wen_cnt[2] - w0), 32'd0);
      check_val("midrst_ready", 32'(req_ready[2]), 32'd1);
      check_val("midrst_resp", {30'd0, resp_valid[2], resp_err[2]}, 32'd0);
      check_val("midrst_mem", mem_addr[2] | mem_wdata[2] | {23'd0, mem_ren[2], mem_wmask[2]}, 32'd0);
    end
    run(2, 1'b1, 3'b010, 32'h8000_0024, 32'h99AA_BBCC, 32'h0, 1'b0, 32'h0, "post_sw");
    check_val("post_sw_data", w_data[2], 32'h99AA_BBCC);

    @(negedge clock);
    check_val("ren_wen_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator driving the data-memory port (addr/wen/wmask/wdata/ren/rdata) of the simulated DPI data memory from the core's execute stage.
- Accepts one load or store per valid/ready handshake.
- Aligns the address and generates the byte mask and shifted write data.
- Holds the access for a programmable number of wait cycles, captures and sign/zero-extends load data, and returns a registered response through a second valid/ready handshake.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- MEM_WAIT, 1, cycles the memory request is held before read data is sampled; range 1..15.

Ports:
- clock  input  1  single clock.
- reset  input  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of clock.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_wen  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 size/sign code (lb/lh/lw/lbu/lhu; sb/sh/sw).
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  XLEN  extended load data; 0 for stores.
- resp_err  output  1  misaligned access or illegal funct3.
- mem_addr  output  XLEN  word-aligned address (req_addr with bits [1:0] cleared).
- mem_ren  output  1  read enable.
- mem_wen  output  1  write enable.
- mem_wmask  output  8  byte mask; bits [7:4] always 0.
- mem_wdata  output  XLEN  lane-shifted store data.
- mem_rdata  input  XLEN  memory read data, valid while mem_ren=1.

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - All mem_* outputs are 0.
  - The wait counter is cleared.
- Reset mid-access abandons the access; no further mem_wen/mem_ren pulse is issued.

- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch the request.
    - If err: go to RESP and issue no memory access.
    - Otherwise: go to ACCESS and load the counter with MEM_WAIT-1.
  - ACCESS: req_ready=0. mem_addr/mem_ren/mem_wmask/mem_wdata are driven from latched registers.
    - Counter decrements each cycle.
    - When the counter is 0: sample mem_rdata into resp_rdata (loads) and go to RESP.
  - RESP: resp_valid=1, req_ready=0. When resp_valid and resp_ready are both 1, return to IDLE with resp_valid=0 on the next edge.

- Memory signal timing:
  - mem_ren stays high for all MEM_WAIT cycles of a load ACCESS.
  - mem_wen is high only in the final ACCESS cycle of a store. It is exactly one cycle per store, because the memory commits on every evaluation while wen is high.
  - mem_ren and mem_wen are never both 1.

- Latency:
  - Accept edge to resp_valid high: MEM_WAIT+1 cycles; error path: 1 cycle.
  - With resp_ready held at 1, throughput is one access per MEM_WAIT+2 cycles.
  - No request is accepted in the same cycle a response completes.

- Let off = req_addr[1:0].
- Misalignment:
  - Half-word access with off[0]=1 is an error.
  - Word access with off≠0 is an error.
  - Byte access is never misaligned.
- Illegal funct3 is an error:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000/001/010.

- Store lane generation:
  - sb: wmask = 0x1<<off, wdata = req_wdata[7:0] replicated into all four bytes.
  - sh: wmask = 0x3<<off, wdata = req_wdata[15:0] replicated into both halves.
  - sw: wmask = 0xF, wdata = req_wdata.

- Load extraction: shifted = mem_rdata >> (8*off).
  - lb sign-extends shifted[7:0]; lbu zero-extends it.
  - lh sign-extends shifted[15:0]; lhu zero-extends it.
  - lw takes shifted directly.

- Response contents:
  - Stores return resp_rdata=0.
  - Errors return resp_rdata=0 and resp_err=1.
  - resp_rdata and resp_err are stable while resp_valid=1 and resp_ready=0.
- Request inputs are ignored outside IDLE; the upstream stage must hold them until handshake completion.

Test Plan:
- Store word, MEM_WAIT=1: req sw addr=0x80000104 wdata=0xDEADBEEF.
  - Exactly one cycle with mem_wen=1, mem_addr=0x80000104, mem_wmask=0xF, mem_wdata=0xDEADBEEF.
  - Then resp_valid=1, resp_err=0, resp_rdata=0.
- Byte store then signed/unsigned loads: sb addr=0x80000103 wdata=0x000000F0.
  - Store drives wmask=0x8 and wdata=0xF0F0F0F0.
  - With mem_rdata=0xF0000000, lb at 0x80000103 returns 0xFFFFFFF0.
  - With the same mem_rdata, lbu returns 0x000000F0.
- Half-word load: lh addr=0x80000002 with mem_rdata=0x8001ABCD returns 0xFFFF8001; lhu returns 0x00008001.
- Misaligned and illegal requests issue no mem_ren/mem_wen and give resp_err=1 one cycle after accept:
  - lw addr=0x80000002.
  - sh addr=0x80000001.
  - load funct3=011.
- Backpressure, MEM_WAIT=3:
  - mem_ren is high for 3 cycles.
  - With resp_ready=0 for 5 cycles, resp_valid and resp_rdata stay stable and req_ready stays 0.
  - The next request is accepted only after the response handshake.
- Reset mid-access: assert reset=0 during ACCESS of a store with MEM_WAIT=4.
  - No mem_wen pulse occurs.
  - After release all outputs are at reset values and req_ready=1.
